pitch_band_tracker: RTL and testbench
=====================================

// Module: pitch_band_tracker
// PURPOSE
// - Sits in the CLOCK_50 domain after the pitch-bin synchroniser; consumes the synchronised FFT peak-bin stream.
// - Classifies each bin into one of NBANDS runtime-programmable frequency bands (band edges are ports).
// - Debounces: a band locks only after HITS consecutive samples; it unlocks after MISSES out-of-band samples or a silence timeout.
// - Drives a stable band index plus a change pulse for the motor command logic.
// PARAMETERS
// - W           10         pitch bin width (log2 of FFT NSamples)
// - NBANDS      4          number of programmable bands (1..16)
// - HITS        4          consecutive same-band samples required to lock or switch (>=1)
// - MISSES      3          consecutive NONE samples that release a lock (>=1)
// - TIMEOUT_CYC 2_500_000  clk cycles without pitch_valid before a lock is released (50 ms @ 50 MHz)
// PORTS
// - clk          in   1                   system clock (CLOCK_50)
// - reset        in   1                   synchronous, active-high
// - enable       in   1                   0: ignore samples, hold IDLE
// - pitch_valid  in   1                   one-cycle strobe, bin valid
// - pitch_bin    in   W                   FFT peak bin index
// - band_lo      in   [NBANDS][W]         inclusive lower edge per band
// - band_hi      in   [NBANDS][W]         inclusive upper edge per band
// - band_idx     out  $clog2(NBANDS+1)    locked band; NBANDS = NONE
// - locked       out  1                   1 while a band is locked
// - band_change  out  1                   one-cycle pulse on every band_idx change
// BEHAVIOUR
// - Reset (and enable=0): state IDLE, band_idx=NBANDS, locked=0, band_change=0, all counters 0. enable=0 while locked releases the lock and pulses band_change once.
// - Classify (comb): bin in band b iff band_lo[b] <= bin <= band_hi[b], unsigned; lowest b wins on overlap; no match or lo>hi -> NONE.
// - Only cycles with pitch_valid=1 and enable=1 advance the FSM; all outputs are registered, 1-cycle latency from the deciding sample.
// - IDLE: band b != NONE -> CAND, cand=b, hits=1 (HITS==1: straight to LOCKED, band_idx=b, pulse). NONE -> stay.
// - CAND: band==cand -> hits+1; when hits==HITS -> LOCKED, band_idx=cand, locked=1, pulse. Other non-NONE band -> cand=new, hits=1. NONE -> IDLE.
// - LOCKED: band==band_idx -> clear cand/hits/miss. Other non-NONE band -> candidate counting as in CAND, misses cleared; on hits==HITS band_idx=cand, pulse, stay LOCKED. NONE -> miss+1, hits cleared; miss==MISSES -> IDLE, band_idx=NBANDS, locked=0, pulse.
// - Timeout: counter clears on every valid sample, increments otherwise, saturates; reaching TIMEOUT_CYC in LOCKED or CAND -> IDLE (pulse only if leaving LOCKED).
// - Simultaneous timeout and valid sample in the same cycle: the sample wins, timeout counter clears.
// - Band edge ports are sampled combinationally each valid cycle; changing them mid-lock takes effect on the next sample, no flush.
// - Counter widths: hits $clog2(HITS+1), miss $clog2(MISSES+1), timeout $clog2(TIMEOUT_CYC+1); all saturate, never wrap.
// - band_change never asserts on two consecutive cycles unless band_idx changed on both.
// STRUCTURE
// - pitch_pkg: state enum {IDLE, CAND, LOCKED}; function band_none(NBANDS); index-width helper.
// - Sub-module pitch_band_lookup (comb, priority classifier: bin + edges -> band index / NONE); one instance.
// - Top: FSM, hits/miss/timeout counters, output registers.
// TESTING (bench: NBANDS=4, HITS=3, MISSES=2, TIMEOUT_CYC=20; bands 0:[10,19] 1:[20,39] 2:[40,79] 3:[80,159])
// - Bins 25,30,22 -> band_idx=1, locked=1, one band_change pulse 1 cycle after third strobe; 25,30 only -> band_idx stays 4.
// - Locked on 1, then 50,60,45 -> band_idx=2 after third, single pulse; 50,25,50 -> stays 1, no pulse.
// - Locked on 1, bins 5,200 -> unlock after second (band_idx=4, pulse); bins 5,25,5 -> stays locked.
// - Locked, no strobes for 20 cycles -> band_idx=4, pulse; strobe on cycle 20 exactly -> lock retained.
// - Overlap: band0=[10,30], bin 25 x3 -> band_idx=0; band2 lo=90>hi=79, bin 85 -> band 3.
// - reset mid-CAND and mid-LOCKED, and enable=0 while locked -> next cycle all outputs at reset values (enable drop pulses once).

Source files
------------

// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch band tracker.
package pitch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    LOCKED
  } state_e;

  // Band index value meaning "no band": one past the last real band.
  function automatic int unsigned band_none(input int unsigned nbands);
    return nbands;
  endfunction

  // Width of a band index able to hold 0..nbands (nbands encodes NONE).
  function automatic int unsigned idx_width(input int unsigned nbands);
    return $clog2(nbands + 1);
  endfunction

endpackage

// File: rtl/pitch_band_lookup.sv
// Priority classifier: maps a pitch bin onto the lowest-numbered band whose
// inclusive [lo, hi] range contains it; NONE if no band matches.
module pitch_band_lookup
  import pitch_pkg::*;
#(
  parameter  int unsigned W      = 10,
  parameter  int unsigned NBANDS = 4,
  localparam int unsigned IW     = idx_width(NBANDS)
) (
  input  logic [W-1:0]             bin_i,
  input  logic [NBANDS-1:0][W-1:0] lo_i,
  input  logic [NBANDS-1:0][W-1:0] hi_i,
  output logic [IW-1:0]            band_o
);

  logic found;

  // First matching band wins; an inverted range (lo > hi) can never match.
  always_comb begin
    band_o = IW'(band_none(NBANDS));
    found  = 1'b0;
    for (int unsigned b = 0; b < NBANDS; b++) begin
      if (!found && (lo_i[b] <= bin_i) && (bin_i <= hi_i[b])) begin
        band_o = IW'(b);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pitch_band_tracker.sv
// Debounced pitch band tracker: classifies each valid pitch bin into a
// programmable band, locks after HITS consecutive hits, releases after
// MISSES consecutive out-of-band samples or a silence timeout.
module pitch_band_tracker
  import pitch_pkg::*;
#(
  parameter  int unsigned W           = 10,
  parameter  int unsigned NBANDS      = 4,
  parameter  int unsigned HITS        = 4,
  parameter  int unsigned MISSES      = 3,
  parameter  int unsigned TIMEOUT_CYC = 2_500_000,
  localparam int unsigned IW          = idx_width(NBANDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     pitch_valid,
  input  logic [W-1:0]             pitch_bin,
  input  logic [NBANDS-1:0][W-1:0] band_lo,
  input  logic [NBANDS-1:0][W-1:0] band_hi,
  output logic [IW-1:0]            band_idx,
  output logic                     locked,
  output logic                     band_change
);

  localparam int unsigned HW = $clog2(HITS + 1);
  localparam int unsigned MW = $clog2(MISSES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] NONE = IW'(band_none(NBANDS));

  state_e        state_q, state_d;
  logic [IW-1:0] cand_q, cand_d;
  logic [HW-1:0] hits_q, hits_d, hits_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [IW-1:0] idx_q, idx_d;
  logic          locked_q, locked_d;
  logic          change_q, change_d;
  logic [IW-1:0] band;

  pitch_band_lookup #(
    .W      (W),
    .NBANDS (NBANDS)
  ) u_lookup (
    .bin_i  (pitch_bin),
    .lo_i   (band_lo),
    .hi_i   (band_hi),
    .band_o (band)
  );

  // Saturating increments; a band differing from the candidate restarts at 1.
  assign hits_inc = (band == cand_q)
                    ? ((hits_q == HW'(HITS)) ? hits_q : hits_q + HW'(1))
                    : HW'(1);
  assign miss_inc = (miss_q == MW'(MISSES)) ? miss_q : miss_q + MW'(1);
  assign tmo_inc  = (tmo_q == TW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + TW'(1);

  // Next-state logic for the tracker FSM, counters and output registers.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    change_d = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      cand_d   = NONE;
      hits_d   = '0;
      miss_d   = '0;
      tmo_d    = '0;
      idx_d    = NONE;
      locked_d = 1'b0;
      change_d = locked_q;
    end else if (pitch_valid) begin
      tmo_d = '0;
      unique case (state_q)
        // IDLE and CAND share one path: in IDLE cand is NONE, so a real band
        // always starts at hits=1, which also covers HITS==1 locking directly.
        IDLE, CAND: begin
          if (band == NONE) begin
            state_d = IDLE;
            cand_d  = NONE;
            hits_d  = '0;
          end else if (hits_inc == HW'(HITS)) begin
            state_d  = LOCKED;
            idx_d    = band;
            locked_d = 1'b1;
            change_d = 1'b1;
            cand_d   = NONE;
            hits_d   = '0;
            miss_d   = '0;
          end else begin
            state_d = CAND;
            cand_d  = band;
            hits_d  = hits_inc;
          end
        end
        LOCKED: begin
          if (band == NONE) begin
            cand_d = NONE;
            hits_d = '0;
            if (miss_inc == MW'(MISSES)) begin
              state_d  = IDLE;
              idx_d    = NONE;
              locked_d = 1'b0;
              change_d = 1'b1;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else if (band == idx_q) begin
            cand_d = NONE;
            hits_d = '0;
            miss_d = '0;
          end else begin
            miss_d = '0;
            if (hits_inc == HW'(HITS)) begin
              idx_d    = band;
              change_d = 1'b1;
              cand_d   = NONE;
              hits_d   = '0;
            end else begin
              cand_d = band;
              hits_d = hits_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      tmo_d = tmo_inc;
      if ((tmo_inc == TW'(TIMEOUT_CYC)) && (state_q != IDLE)) begin
        state_d = IDLE;
        cand_d  = NONE;
        hits_d  = '0;
        miss_d  = '0;
        if (state_q == LOCKED) begin
          idx_d    = NONE;
          locked_d = 1'b0;
          change_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= NONE;
      hits_q   <= '0;
      miss_q   <= '0;
      tmo_q    <= '0;
      idx_q    <= NONE;
      locked_q <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
      change_q <= change_d;
    end
  end

  assign band_idx    = idx_q;
  assign locked      = locked_q;
  assign band_change = change_q;

endmodule

// File: tb/tb_pitch_band_tracker.sv
// Scoreboard bench for pitch_band_tracker: a history-based reference model
// predicts the outputs after each clock; a monitor compares them.
module tb_pitch_band_tracker;

  localparam int W     = 10;
  localparam int NB    = 4;
  localparam int HITS  = 3;
  localparam int MISS  = 2;
  localparam int TMO   = 20;
  localparam int NONE  = NB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 pitch_valid;
  logic [W-1:0]         pitch_bin;
  logic [NB-1:0][W-1:0] band_lo;
  logic [NB-1:0][W-1:0] band_hi;
  logic [2:0]           band_idx;
  logic                 locked;
  logic                 band_change;

  pitch_band_tracker #(
    .W           (W),
    .NBANDS      (NB),
    .HITS        (HITS),
    .MISSES      (MISS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pitch_valid (pitch_valid),
    .pitch_bin   (pitch_bin),
    .band_lo     (band_lo),
    .band_hi     (band_hi),
    .band_idx    (band_idx),
    .locked      (locked),
    .band_change (band_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit lk;
    bit ch;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: recent classified samples plus lock status.
  int m_idx = NONE;
  bit m_lk  = 1'b0;
  int m_cnt = 0;
  int hist[$];

  function automatic int classify(input int bin);
    for (int b = 0; b < NB; b++)
      if (int'(band_lo[b]) <= bin && bin <= int'(band_hi[b])) return b;
    return NONE;
  endfunction

  function automatic bit last_all(input int n, input int v);
    if (hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (hist[hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus; the model predicts outputs after the next edge.
  task automatic step(input bit r, input bit en, input bit v, input int bin);
    int b;
    bit ch;
    @(negedge clk);
    reset       = r;
    enable      = en;
    pitch_valid = v;
    pitch_bin   = W'(bin);
    ch = 1'b0;
    if (r) begin
      hist.delete();
      m_idx = NONE; m_lk = 1'b0; m_cnt = 0;
    end else if (!en) begin
      ch = m_lk;
      hist.delete();
      m_idx = NONE; m_lk = 1'b0; m_cnt = 0;
    end else if (v) begin
      b = classify(bin);
      m_cnt = 0;
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      if (m_lk && last_all(MISS, NONE)) begin
        m_lk = 1'b0; m_idx = NONE; ch = 1'b1;
        hist.delete();
      end else if (b != NONE && b != m_idx && last_all(HITS, b)) begin
        m_idx = b; m_lk = 1'b1; ch = 1'b1;
      end
    end else begin
      if (m_cnt < TMO) m_cnt++;
      if (m_cnt == TMO) begin
        hist.delete();
        if (m_lk) begin
          m_lk = 1'b0; m_idx = NONE; ch = 1'b1;
        end
      end
    end
    sbq.push_back('{m_idx, m_lk, ch});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1, 0, 0);
  endtask

  // Strobe a bin once, followed by one quiet cycle.
  task automatic tone(input int bin, input int n);
    repeat (n) begin
      step(0, 1, 1, bin);
      step(0, 1, 0, 0);
    end
  endtask

  // Edge changes land just after an active edge so the model sees them too.
  task automatic set_edges(input int b, input int lo, input int hi);
    @(posedge clk);
    #1;
    band_lo[b] = W'(lo);
    band_hi[b] = W'(hi);
  endtask

  // Monitor: compare registered outputs shortly after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      if (band_idx !== 3'(e.idx) || locked !== e.lk || band_change !== e.ch) begin
        miscompares++;
        $display("FAIL outputs t=%0t got idx=%0d locked=%0b change=%0b required idx=%0d locked=%0b change=%0b",
                 $time, band_idx, locked, band_change, e.idx, e.lk, e.ch);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired with %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int tone_bin;
    int r;
    reset = 1'b1; enable = 1'b0; pitch_valid = 1'b0; pitch_bin = '0;
    band_lo[0] = 10; band_hi[0] = 19;
    band_lo[1] = 20; band_hi[1] = 39;
    band_lo[2] = 40; band_hi[2] = 79;
    band_lo[3] = 80; band_hi[3] = 159;

    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    idle(2);

    // Two hits only, then broken by NONE; then a full three-hit lock.
    tone(25, 1); tone(30, 1); tone(5, 1); idle(2);
    tone(25, 1); tone(30, 1); tone(22, 1); idle(2);
    // Switch to band 2, back to 1, then an interrupted candidate.
    tone(50, 1); tone(60, 1); tone(45, 1);
    tone(25, 3);
    tone(50, 1); tone(25, 1); tone(50, 1);
    // Two misses unlock; an in-band sample resets the miss count.
    tone(5, 1); tone(200, 1); idle(2);
    tone(25, 3);
    tone(5, 1); tone(25, 1); tone(5, 1);
    // Timeout: strobe on the 20th quiet cycle keeps lock; 20 quiet cycles drop it.
    step(0, 1, 1, 25);
    idle(19);
    step(0, 1, 1, 25);
    idle(20);
    idle(3);
    // Overlap priority and an inverted band range.
    set_edges(0, 10, 30);
    tone(25, 3);
    set_edges(0, 10, 19);
    set_edges(2, 90, 79);
    tone(85, 3);
    set_edges(2, 40, 79);
    // Reset mid-candidate, reset mid-lock, enable drop while locked.
    tone(5, 2);
    tone(25, 2); step(1, 1, 0, 0); idle(2);
    tone(25, 3); step(1, 1, 0, 0); idle(2);
    tone(25, 3); step(0, 0, 1, 25); step(0, 0, 0, 0); idle(2);

    // Randomized phase: sticky tones, noise bins, silences, resets, enable drops.
    tone_bin = 25;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        step(1, 1, 0, 0);
      end else if (r < 8) begin
        step(0, 0, 1'($urandom_range(0, 1)), tone_bin);
      end else if (r < 12) begin
        idle(int'($urandom_range(15, 24)));
      end else if (r < 14) begin
        set_edges(1, int'($urandom_range(15, 30)), int'($urandom_range(28, 45)));
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 6))
            0: tone_bin = 5;
            1: tone_bin = 15;
            2: tone_bin = 25;
            3: tone_bin = 50;
            4: tone_bin = 100;
            5: tone_bin = 200;
            default: tone_bin = int'($urandom_range(0, 1023));
          endcase
        end
        step(0, 1, ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : tone_bin);
      end
    end

    @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain pending=%0d required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
